// File: rtl/video_pattern_generator.sv
// video_pattern_generator: derives pixel/line coordinates from timing strobes and drives
// one of four 24-bit test patterns, with strobes delayed 2 cycles to stay aligned with the pixels.
module video_pattern_generator #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES = 720,
  parameter int MOVE_STEP = 4,
  parameter int BAR_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        ad_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        vs_o,
  output logic        hs_o,
  output logic        ad_o,
  output logic [23:0] rgb_o,
  output logic [15:0] frame_cnt_o
);
  localparam int XW = $clog2(ACTIVE_H_PIXELS);
  localparam int YW = $clog2(ACTIVE_LINES);
  localparam int BW = $clog2(ACTIVE_H_PIXELS / 8);
  localparam logic [XW-1:0] X_MAX = XW'(ACTIVE_H_PIXELS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ACTIVE_LINES - 1);
  localparam logic [BW-1:0] BP_MAX = BW'(ACTIVE_H_PIXELS / 8 - 1);
  localparam logic [XW:0] STEP = (XW+1)'(MOVE_STEP);
  localparam logic [XW:0] BAR = (XW+1)'(BAR_WIDTH);
  localparam logic [XW:0] H_PIX = (XW+1)'(ACTIVE_H_PIXELS);
  logic          vs_q, ad_q, vs_rise, ad_fall;
  logic [XW-1:0] x, off, s1_x, s1_off;
  logic [YW-1:0] y;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx, s1_idx;
  logic [1:0]    pat, s1_pat;
  logic          s1_vs, s1_hs, s1_ad, s1_y5;
  logic [XW:0]   off_nxt;
  logic [23:0]   bar_col, chk_col, ramp_col, scr_col, pix;
  assign vs_rise = vs_i & ~vs_q;
  assign ad_fall = ~ad_i & ad_q;
  assign off_nxt = {1'b0, off} + STEP;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vs_q <= 1'b0;
      ad_q <= 1'b0;
      x <= '0;
      y <= '0;
      bar_px <= '0;
      bar_idx <= '0;
      pat <= '0;
      off <= '0;
      frame_cnt_o <= '0;
    end else begin
      vs_q <= vs_i;
      ad_q <= ad_i;
      if (ad_fall) x <= '0;
      else if (ad_i && x != X_MAX) x <= x + XW'(1);
      if (vs_rise) y <= '0;
      else if (ad_fall && y != Y_MAX) y <= y + YW'(1);
      // bar index tracked incrementally so no divide by line/8 is needed
      if (ad_fall) begin
        bar_px <= '0;
        bar_idx <= '0;
      end else if (ad_i) begin
        bar_px <= (bar_px == BP_MAX) ? '0 : bar_px + BW'(1);
        if (bar_px == BP_MAX && bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end
      if (vs_rise) begin
        pat <= pattern_sel_i;
        off <= (off_nxt >= H_PIX) ? '0 : off_nxt[XW-1:0];
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      {s1_vs, s1_hs, s1_ad, s1_y5} <= '0;
      s1_x <= '0;
      s1_off <= '0;
      s1_idx <= '0;
      s1_pat <= '0;
      {vs_o, hs_o, ad_o} <= '0;
      rgb_o <= '0;
    end else begin
      {s1_vs, s1_hs, s1_ad, s1_y5} <= {vs_i, hs_i, ad_i, y[5]};
      s1_x <= x;
      s1_off <= off;
      s1_idx <= bar_idx;
      s1_pat <= pat;
      {vs_o, hs_o, ad_o} <= {s1_vs, s1_hs, s1_ad};
      rgb_o <= s1_ad ? pix : '0;
    end
  end
  assign bar_col = {{8{~s1_idx[1]}}, {8{~s1_idx[2]}}, {8{~s1_idx[0]}}};
  assign chk_col = {24{s1_x[5] ^ s1_y5}};
  assign ramp_col = {3{s1_x[7:0]}};
  assign scr_col = {24{(s1_x >= s1_off) && ({1'b0, s1_x} < {1'b0, s1_off} + BAR)}};
  assign pix = (s1_pat == 2'd0) ? bar_col :
               (s1_pat == 2'd1) ? chk_col :
               (s1_pat == 2'd2) ? ramp_col : scr_col;
endmodule

// File: tb/tb_video_pattern_generator.sv
// tb_video_pattern_generator: directed vector table plus hand sequences for reset, latency,
// pattern switching, scrolling wrap, saturation and frame counter wrap.
module tb_video_pattern_generator;
  logic        clk_i, rst_n_i, vs_i, hs_i, ad_i;
  logic [1:0]  pattern_sel_i;
  logic        vs_o, hs_o, ad_o;
  logic [23:0] rgb_o;
  logic [15:0] frame_cnt_o;
  int errors = 0, checks = 0, n, blank_bad, fexp, bad;
  logic [23:0] cap [0:1399];
  typedef struct {
    logic [1:0]  sel;
    int          ln;
    int          px;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [18];
  video_pattern_generator dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .vs_i(vs_i), .hs_i(hs_i), .ad_i(ad_i),
    .pattern_sel_i(pattern_sel_i), .vs_o(vs_o), .hs_o(hs_o), .ad_o(ad_o),
    .rgb_o(rgb_o), .frame_cnt_o(frame_cnt_o)
  );
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic line(input int len);
    n = 0;
    blank_bad = 0;
    for (int i = 0; i < len + 4; i++) begin
      ad_i = (i < len);
      step();
      if (ad_o) begin
        if (n < 1400) cap[n] = rgb_o;
        n++;
      end else if (rgb_o !== 24'h0) blank_bad++;
    end
    ad_i = 1'b0;
  endtask
  task automatic vs_pulse(input logic [1:0] sel);
    pattern_sel_i = sel;
    vs_i = 1'b1;
    step();
    step();
    vs_i = 1'b0;
    step();
    step();
    fexp++;
  endtask
  task automatic vs_fast();
    vs_i = 1'b1;
    step();
    vs_i = 1'b0;
    step();
  endtask
  initial begin
    vecs[0]  = '{2'd0, 0, 0, 24'hFFFFFF};
    vecs[1]  = '{2'd0, 0, 159, 24'hFFFFFF};
    vecs[2]  = '{2'd0, 0, 160, 24'hFFFF00};
    vecs[3]  = '{2'd0, 0, 320, 24'h00FFFF};
    vecs[4]  = '{2'd0, 0, 480, 24'h00FF00};
    vecs[5]  = '{2'd0, 0, 640, 24'hFF00FF};
    vecs[6]  = '{2'd0, 0, 800, 24'hFF0000};
    vecs[7]  = '{2'd0, 0, 1119, 24'h0000FF};
    vecs[8]  = '{2'd0, 0, 1120, 24'h000000};
    vecs[9]  = '{2'd0, 0, 1279, 24'h000000};
    vecs[10] = '{2'd1, 0, 31, 24'h000000};
    vecs[11] = '{2'd1, 0, 32, 24'hFFFFFF};
    vecs[12] = '{2'd1, 32, 0, 24'hFFFFFF};
    vecs[13] = '{2'd1, 32, 32, 24'h000000};
    vecs[14] = '{2'd1, 64, 40, 24'hFFFFFF};
    vecs[15] = '{2'd2, 0, 255, 24'hFFFFFF};
    vecs[16] = '{2'd2, 0, 256, 24'h000000};
    vecs[17] = '{2'd2, 5, 100, 24'h646464};
    {vs_i, hs_i, ad_i} = 3'b000;
    pattern_sel_i = 2'd0;
    rst_n_i = 1'b0;
    fexp = 0;
    repeat (3) step();
    chk("reset vs_o", vs_o, 0);
    chk("reset hs_o", hs_o, 0);
    chk("reset ad_o", ad_o, 0);
    chk("reset rgb_o", rgb_o, 0);
    chk("reset frame_cnt", frame_cnt_o, 0);
    rst_n_i = 1'b1;
    step();
    vs_pulse(2'd0);
    ad_i = 1'b1;
    repeat (3) step();
    chk("pre-reset ad_o", ad_o, 1);
    chk("pre-reset rgb_o", rgb_o, 24'hFFFFFF);
    chk("pre-reset frame_cnt", frame_cnt_o, fexp);
    rst_n_i = 1'b0;
    #1;
    chk("async reset ad_o", ad_o, 0);
    chk("async reset rgb_o", rgb_o, 0);
    chk("async reset frame_cnt", frame_cnt_o, 0);
    ad_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    fexp = 0;
    step();
    step();
    {hs_i, ad_i} = 2'b11;
    step();
    {hs_i, ad_i} = 2'b00;
    chk("latency c1 ad_o", ad_o, 0);
    step();
    chk("latency c2 ad_o", ad_o, 1);
    chk("latency c2 hs_o", hs_o, 1);
    step();
    chk("latency c3 ad_o", ad_o, 0);
    chk("latency c3 hs_o", hs_o, 0);
    vs_i = 1'b1;
    step();
    vs_i = 1'b0;
    fexp++;
    chk("latency c1 vs_o", vs_o, 0);
    step();
    chk("latency c2 vs_o", vs_o, 1);
    step();
    chk("latency c3 vs_o", vs_o, 0);
    for (int v = 0; v < 18; v++) begin
      vs_pulse(vecs[v].sel);
      repeat (vecs[v].ln) line(1);
      line(vecs[v].px + 1);
      chk($sformatf("vec%0d count", v), n, vecs[v].px + 1);
      chk($sformatf("vec%0d blank", v), blank_bad, 0);
      chk($sformatf("vec%0d pat%0d y%0d x%0d", v, vecs[v].sel, vecs[v].ln, vecs[v].px),
          cap[vecs[v].px], vecs[v].exp);
    end
    vs_pulse(2'd0);
    line(200);
    chk("switch before", cap[160], 24'hFFFF00);
    pattern_sel_i = 2'd2;
    line(200);
    chk("switch mid-frame held", cap[160], 24'hFFFF00);
    chk("switch frame_cnt before", frame_cnt_o, fexp);
    vs_pulse(2'd2);
    chk("switch frame_cnt after", frame_cnt_o, fexp);
    line(200);
    chk("switch after vs", cap[160], 24'hA0A0A0);
    vs_pulse(2'd0);
    line(1300);
    chk("sat count", n, 1300);
    chk("sat blank", blank_bad, 0);
    bad = 0;
    for (int i = 0; i < 160; i++) if (cap[i] !== 24'hFFFFFF) bad++;
    chk("sat first bar white", bad, 0);
    bad = 0;
    for (int i = 1120; i < 1300; i++) if (cap[i] !== 24'h0) bad++;
    chk("sat last bar and overrun black", bad, 0);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    fexp = 0;
    step();
    pattern_sel_i = 2'd3;
    line(20);
    chk("post-reset pattern 0", cap[16], 24'hFFFFFF);
    repeat (3) vs_pulse(2'd3);
    line(40);
    chk("scroll3 x11", cap[11], 24'h0);
    chk("scroll3 x12", cap[12], 24'hFFFFFF);
    chk("scroll3 x27", cap[27], 24'hFFFFFF);
    chk("scroll3 x28", cap[28], 24'h0);
    repeat (316) vs_pulse(2'd3);
    line(1280);
    chk("scroll319 x1275", cap[1275], 24'h0);
    chk("scroll319 x1276", cap[1276], 24'hFFFFFF);
    chk("scroll319 x1279", cap[1279], 24'hFFFFFF);
    vs_pulse(2'd3);
    line(40);
    chk("scroll320 x0", cap[0], 24'hFFFFFF);
    chk("scroll320 x15", cap[15], 24'hFFFFFF);
    chk("scroll320 x16", cap[16], 24'h0);
    chk("scroll320 frame_cnt", frame_cnt_o, fexp);
    force dut.frame_cnt_o = 16'hFFFF;
    #1;
    release dut.frame_cnt_o;
    bad = 0;
    while (frame_cnt_o !== 16'hFFFF && bad < 70000) begin
      vs_fast();
      bad++;
    end
    vs_fast();
    chk("frame wrap to 0", frame_cnt_o, 16'h0000);
    vs_fast();
    chk("frame after wrap", frame_cnt_o, 16'h0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
